// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared widths, step geometry and FSM encoding for the sqrt blocks
// SQRT_RECON_RADIX4_EN selects two multiplier bits per reconstruction step.
package sqrt_pkg;
   localparam int QW = 16;
   localparam int DW = 2 * QW;
   localparam int RW = QW + 1;
   localparam int CW = $clog2(QW);
`ifdef SQRT_RECON_RADIX4_EN
   localparam int RB = 2;
`else
   localparam int RB = 1;
`endif
   localparam int STEPS = QW / RB;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/sqrt_recon_step.sv
// rtl/sqrt_recon_step.sv - one shift-add squaring iteration: acc + (mcand * mbits) << shift
// SQRT_RECON_RADIX4_EN widens mbits to two bits.
module sqrt_recon_step
   import sqrt_pkg::*;
(
   input  logic [DW:0]   acc,
   input  logic [QW-1:0] mcand,
   input  logic [RB-1:0] mbits,
   input  logic [CW-1:0] shift,
   output logic [DW:0]   acc_next
);
   logic [DW:0] ext;
   logic [DW:0] pp;

   always_comb begin
      ext = {{(DW+1-QW){1'b0}}, mcand};
`ifdef SQRT_RECON_RADIX4_EN
      pp = (mbits[0] ? ext : '0) + (mbits[1] ? (ext << 1) : '0);
`else
      pp = mbits[0] ? ext : '0;
`endif
      acc_next = acc + (pp << shift);
   end
endmodule

// File: rtl/sqrt_reconstruct_seq.sv
// rtl/sqrt_reconstruct_seq.sv - iterative D = Q*Q + R rebuild with valid/ready on both sides
// SQRT_RECON_RADIX4_EN halves the number of CALC cycles.
module sqrt_reconstruct_seq
   import sqrt_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [QW-1:0] q,
   input  logic [RW-1:0] r,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] d,
   output logic          ovf,
   output logic          rem_err
);
   state_t        state_q, state_d;
   logic [DW:0]   acc_q, acc_d;
   logic [QW-1:0] mcand_q, mcand_d;
   logic [QW-1:0] mplier_q, mplier_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rem_err_r_q, rem_err_r_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] d_q, d_d;
   logic          ovf_q, ovf_d;
   logic          rem_err_q, rem_err_d;

   logic [DW:0]   step_acc;
   logic [CW-1:0] step_shift;

   assign step_shift = cnt_q << (RB - 1);

   sqrt_recon_step u_step (
      .acc      (acc_q),
      .mcand    (mcand_q),
      .mbits    (mplier_q[RB-1:0]),
      .shift    (step_shift),
      .acc_next (step_acc)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      rem_err_r_d = rem_err_r_q;
      out_valid_d = out_valid_q;
      d_d         = d_q;
      ovf_d       = ovf_q;
      rem_err_d   = rem_err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d       = {{(DW+1-RW){1'b0}}, r};
               mcand_d     = q;
               mplier_d    = q;
               cnt_d       = '0;
               rem_err_r_d = r > {q, 1'b0};
               state_d     = CALC;
            end
         end
         CALC: begin
            acc_d    = step_acc;
            mplier_d = mplier_q >> RB;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // First DONE cycle captures the result into the output registers.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               d_d         = acc_q[DW-1:0];
               ovf_d       = acc_q[DW];
               rem_err_d   = rem_err_r_q;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         rem_err_r_q <= 1'b0;
         out_valid_q <= 1'b0;
         d_q         <= '0;
         ovf_q       <= 1'b0;
         rem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
         rem_err_r_q <= rem_err_r_d;
         out_valid_q <= out_valid_d;
         d_q         <= d_d;
         ovf_q       <= ovf_d;
         rem_err_q   <= rem_err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign ovf       = ovf_q;
   assign rem_err   = rem_err_q;
endmodule

// File: tb/tb_sqrt_reconstruct_seq.sv
// tb/tb_sqrt_reconstruct_seq.sv - directed bench for sqrt_reconstruct_seq
// Build with SQRT_RECON_RADIX4_EN to exercise the two-bit-per-step mode.
module tb_sqrt_reconstruct_seq;
`ifdef SQRT_RECON_RADIX4_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 17;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] q;
   logic [16:0] r;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] d;
   logic        ovf;
   logic        rem_err;

   int total = 0;
   int bad   = 0;

   sqrt_reconstruct_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .r         (r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .ovf       (ovf),
      .rem_err   (rem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [15:0] qi, input logic [16:0] ri,
                         input logic [31:0] ed, input logic eo, input logic ee,
                         input int hold);
      int lat;
      @(negedge clk);
      q = qi;
      r = ri;
      in_valid = 1'b1;
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (lat == 3) begin
            chk("in_ready_calc", in_ready, 0);
            q = 16'hffff;
            r = 17'h1ffff;
            in_valid = 1'b1;
         end
         if (lat == 4) in_valid = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, LAT);
      chk("d", d, ed);
      chk("ovf", ovf, eo);
      chk("rem_err", rem_err, ee);
      chk("in_ready_done", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_d", d, ed);
         chk("hold_in_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("post_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      chk("post_d_held", d, ed);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      q         = '0;
      r         = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_d", d, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_rem_err", rem_err, 0);

      run_op(16'd0,     17'd0,      32'd0,          1'b0, 1'b0, 0);
      run_op(16'd3,     17'd6,      32'd15,         1'b0, 1'b0, 0);
      run_op(16'd200,   17'd0,      32'd40000,      1'b0, 1'b0, 0);
      run_op(16'd16,    17'd0,      32'd256,        1'b0, 1'b0, 0);
      run_op(16'd65535, 17'd131070, 32'hffffffff,   1'b0, 1'b0, 0);
      run_op(16'd65535, 17'd131071, 32'd0,          1'b1, 1'b1, 0);
      run_op(16'd4,     17'd9,      32'd25,         1'b0, 1'b1, 5);

      // Abort a calculation partway through with an asynchronous reset.
      @(negedge clk);
      q = 16'd1234;
      r = 17'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_d", d, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_in_ready", in_ready, 1);
      run_op(16'd512, 17'd0, 32'd262144, 1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
